mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/mem_stage_data_mem.sv | 24 ++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: default widths, the RET
// redirect state encoding and the writeback-source encoding.
package mem_stage_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      RET_IDLE     = 2'b00,
      RET_REDIRECT = 2'b01,
      RET_DRAIN    = 2'b10
   } ret_state_t;

   typedef enum logic [1:0] {
      WB_SEL_ALU = 2'b00,
      WB_SEL_MEM = 2'b01,
      WB_SEL_IO  = 2'b10
   } wb_sel_t;

   // A load beats an IN when a malformed instruction asserts both.
   function automatic wb_sel_t wb_select(input logic mem_to_reg, input logic io_read);
      if (mem_to_reg) return WB_SEL_MEM;
      if (io_read) return WB_SEL_IO;
      return WB_SEL_ALU;
   endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data/stack memory: synchronous write, combinational read, no reset so the
// contents survive a pipeline reset.
module mem_stage_data_mem
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: owns data memory and the I/O ports, selects the
// writeback value, registers MEM/WB and turns a RET into a one-cycle redirect.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              wb_reg_write_in,
   input  logic              mem_write_in,
   input  logic              mem_to_reg_in,
   input  logic              io_read_in,
   input  logic              io_write_in,
   input  logic              sp_update_in,
   input  logic              update_flags_in,
   input  logic              is_ret_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [DATA_W-1:0] extra_data_in,
   input  logic [1:0]        write_addr_in,
   input  logic [1:0]        sp_addr_in,
   input  logic [3:0]        flags_in,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic              wb_reg_write_out,
   output logic              update_flags_out,
   output logic              sp_update_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [DATA_W-1:0] sp_data_out,
   output logic [1:0]        write_addr_out,
   output logic [1:0]        sp_addr_out,
   output logic [3:0]        flags_out,
   output logic              pc_load,
   output logic [DATA_W-1:0] pc_target,
   output logic              flush_out
);

   ret_state_t        state;
   ret_state_t        next_state;
   wb_sel_t           wb_sel;
   logic              drain;
   logic              ret_fire;
   logic              mem_we;
   logic              out_we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] in_meta;
   logic [DATA_W-1:0] in_sync;
   logic [DATA_W-1:0] wb_data_next;

   assign addr   = alu_result_in[ADDR_W-1:0];
   assign mem_we = mem_write_in & ~stall_in & ~drain;
   assign out_we = io_write_in & ~stall_in & ~drain;
   assign wb_sel = wb_select(mem_to_reg_in, io_read_in);

   mem_stage_data_mem #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_data_mem (
      .clk  (clk),
      .we   (mem_we),
      .addr (addr),
      .wdata(store_data_in),
      .rdata(rd_data)
   );

   // The input port is asynchronous to the core, so it crosses two flops
   // before any IN may observe it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_meta <= '0;
         in_sync <= '0;
      end else begin
         in_meta <= in_port;
         in_sync <= in_meta;
      end
   end

   always_comb begin
      wb_data_next = alu_result_in;
      unique case (wb_sel)
         WB_SEL_MEM: wb_data_next = rd_data;
         WB_SEL_IO:  wb_data_next = in_sync;
         default:    wb_data_next = alu_result_in;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RET_IDLE;
      else      state <= next_state;
   end

   // REDIRECT ignores stall so the pulse is never stretched; DRAIN waits for
   // the wrong-path instruction to actually leave the slot before re-arming.
   always_comb begin
      next_state = state;
      pc_load    = 1'b0;
      flush_out  = 1'b0;
      drain      = 1'b0;
      ret_fire   = 1'b0;
      unique case (state)
         RET_IDLE: begin
            if (is_ret_in & mem_to_reg_in & ~stall_in) begin
               ret_fire   = 1'b1;
               next_state = RET_REDIRECT;
            end
         end
         RET_REDIRECT: begin
            pc_load    = 1'b1;
            flush_out  = 1'b1;
            next_state = RET_DRAIN;
         end
         RET_DRAIN: begin
            drain = 1'b1;
            if (!stall_in) next_state = RET_IDLE;
         end
         default: next_state = RET_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_target <= '0;
      end else if (ret_fire) begin
         pc_target <= rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_port <= '0;
      end else if (out_we) begin
         out_port <= store_data_in;
      end
   end

   // MEM/WB boundary; the instruction sitting in the drain slot keeps its
   // data fields but loses every architectural side effect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_reg_write_out <= 1'b0;
         update_flags_out <= 1'b0;
         sp_update_out    <= 1'b0;
         wb_data_out      <= '0;
         sp_data_out      <= '0;
         write_addr_out   <= '0;
         sp_addr_out      <= '0;
         flags_out        <= '0;
      end else if (!stall_in) begin
         wb_reg_write_out <= wb_reg_write_in & ~drain;
         update_flags_out <= update_flags_in & ~drain;
         sp_update_out    <= sp_update_in & ~drain;
         wb_data_out      <= wb_data_next;
         sp_data_out      <= extra_data_in;
         write_addr_out   <= write_addr_in;
         sp_addr_out      <= sp_addr_in;
         flags_out        <= flags_in;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the stage.
module tb_mem_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       stall_in, wb_reg_write_in, mem_write_in, mem_to_reg_in;
   logic       io_read_in, io_write_in, sp_update_in, update_flags_in, is_ret_in;
   logic [7:0] alu_result_in, store_data_in, extra_data_in, in_port;
   logic [1:0] write_addr_in, sp_addr_in;
   logic [3:0] flags_in;

   logic [7:0] out_port_a, wb_data_a, sp_data_a, pc_target_a;
   logic       wb_reg_write_a, update_flags_a, sp_update_a, pc_load_a, flush_a;
   logic [1:0] write_addr_a, sp_addr_a;
   logic [3:0] flags_a;
   logic [7:0] out_port_b, wb_data_b, sp_data_b, pc_target_b;
   logic       wb_reg_write_b, update_flags_b, sp_update_b, pc_load_b, flush_b;
   logic [1:0] write_addr_b, sp_addr_b;
   logic [3:0] flags_b;

   int errors = 0;
   int checks = 0;

   // Reference model state: what the MEM/WB boundary and ports should show.
   logic [7:0] mem8 [256];
   logic [7:0] mem4 [16];
   logic [7:0] ip_q [$];
   logic       e_wbw, e_uf, e_spu;
   logic [7:0] e_wbd8, e_wbd4, e_spd, e_out, e_pct8, e_pct4;
   logic [1:0] e_wa, e_sa;
   logic [3:0] e_fl;
   int         phase;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(8), .DATA_W(8)) dut_a (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .wb_reg_write_in(wb_reg_write_in), .mem_write_in(mem_write_in),
      .mem_to_reg_in(mem_to_reg_in), .io_read_in(io_read_in), .io_write_in(io_write_in),
      .sp_update_in(sp_update_in), .update_flags_in(update_flags_in), .is_ret_in(is_ret_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in), .extra_data_in(extra_data_in),
      .write_addr_in(write_addr_in), .sp_addr_in(sp_addr_in), .flags_in(flags_in),
      .in_port(in_port), .out_port(out_port_a),
      .wb_reg_write_out(wb_reg_write_a), .update_flags_out(update_flags_a),
      .sp_update_out(sp_update_a), .wb_data_out(wb_data_a), .sp_data_out(sp_data_a),
      .write_addr_out(write_addr_a), .sp_addr_out(sp_addr_a), .flags_out(flags_a),
      .pc_load(pc_load_a), .pc_target(pc_target_a), .flush_out(flush_a)
   );

   mem_stage #(.ADDR_W(4), .DATA_W(8)) dut_b (
      .clk(clk), .rst(rst), .stall_in(stall_in),
      .wb_reg_write_in(wb_reg_write_in), .mem_write_in(mem_write_in),
      .mem_to_reg_in(mem_to_reg_in), .io_read_in(io_read_in), .io_write_in(io_write_in),
      .sp_update_in(sp_update_in), .update_flags_in(update_flags_in), .is_ret_in(is_ret_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in), .extra_data_in(extra_data_in),
      .write_addr_in(write_addr_in), .sp_addr_in(sp_addr_in), .flags_in(flags_in),
      .in_port(in_port), .out_port(out_port_b),
      .wb_reg_write_out(wb_reg_write_b), .update_flags_out(update_flags_b),
      .sp_update_out(sp_update_b), .wb_data_out(wb_data_b), .sp_data_out(sp_data_b),
      .write_addr_out(write_addr_b), .sp_addr_out(sp_addr_b), .flags_out(flags_b),
      .pc_load(pc_load_b), .pc_target(pc_target_b), .flush_out(flush_b)
   );

   wire [44:0] dut_a_vec = {wb_reg_write_a, update_flags_a, sp_update_a, wb_data_a, sp_data_a,
                            write_addr_a, sp_addr_a, flags_a, out_port_a, pc_load_a, flush_a,
                            pc_target_a};
   wire [44:0] dut_b_vec = {wb_reg_write_b, update_flags_b, sp_update_b, wb_data_b, sp_data_b,
                            write_addr_b, sp_addr_b, flags_b, out_port_b, pc_load_b, flush_b,
                            pc_target_b};

   function automatic logic [44:0] exp_vec(input logic [7:0] wbd, input logic [7:0] pct);
      logic redir;
      redir = (phase == 1);
      return {e_wbw, e_uf, e_spu, wbd, e_spd, e_wa, e_sa, e_fl, e_out, redir, redir, pct};
   endfunction

   task automatic model_reset();
      {e_wbw, e_uf, e_spu} = 3'b000;
      {e_wbd8, e_wbd4, e_spd, e_out, e_pct8, e_pct4} = '0;
      {e_wa, e_sa, e_fl} = '0;
      phase = 0;
      ip_q = '{8'h00, 8'h00};
   endtask

   // One clock edge of the stage as seen by the program: reads see memory
   // before the edge's write, an IN sees the port from two edges ago, and a
   // RET costs a redirect cycle followed by one squashed slot.
   task automatic model_edge();
      logic [7:0] rd8, rd4, isync;
      logic       squashed;
      if (!rst) begin
         model_reset();
         return;
      end
      isync    = ip_q[0];
      rd8      = mem8[alu_result_in];
      rd4      = mem4[alu_result_in[3:0]];
      squashed = (phase == 2);
      if (!stall_in) begin
         e_wbd8 = mem_to_reg_in ? rd8 : (io_read_in ? isync : alu_result_in);
         e_wbd4 = mem_to_reg_in ? rd4 : (io_read_in ? isync : alu_result_in);
         e_wbw  = wb_reg_write_in && !squashed;
         e_uf   = update_flags_in && !squashed;
         e_spu  = sp_update_in && !squashed;
         e_spd  = extra_data_in;
         e_wa   = write_addr_in;
         e_sa   = sp_addr_in;
         e_fl   = flags_in;
         if (mem_write_in && !squashed) begin
            mem8[alu_result_in]      = store_data_in;
            mem4[alu_result_in[3:0]] = store_data_in;
         end
         if (io_write_in && !squashed) e_out = store_data_in;
      end
      if (phase == 0) begin
         if (is_ret_in && mem_to_reg_in && !stall_in) begin
            phase  = 1;
            e_pct8 = rd8;
            e_pct4 = rd4;
         end
      end else if (phase == 1) begin
         phase = 2;
      end else if (!stall_in) begin
         phase = 0;
      end
      ip_q.push_back(in_port);
      void'(ip_q.pop_front());
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      stall_in        = 1'b0;
      wb_reg_write_in = 1'b0;
      mem_write_in    = 1'b0;
      mem_to_reg_in   = 1'b0;
      io_read_in      = 1'b0;
      io_write_in     = 1'b0;
      sp_update_in    = 1'b0;
      update_flags_in = 1'b0;
      is_ret_in       = 1'b0;
      alu_result_in   = 8'h00;
      store_data_in   = 8'h00;
      extra_data_in   = 8'h00;
      write_addr_in   = 2'b00;
      sp_addr_in      = 2'b00;
      flags_in        = 4'h0;
   endtask

   task automatic set_op(input logic wbw, input logic mw, input logic m2r, input logic ior,
                         input logic iow, input logic ret, input logic [7:0] alu,
                         input logic [7:0] st);
      clear_inputs();
      wb_reg_write_in = wbw;
      mem_write_in    = mw;
      mem_to_reg_in   = m2r;
      io_read_in      = ior;
      io_write_in     = iow;
      is_ret_in       = ret;
      alu_result_in   = alu;
      store_data_in   = st;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      in_port = 8'h00;
      model_reset();
      #2;
      checks++;
      if (dut_a_vec !== 45'd0) begin
         errors++;
         $display("[TB] FAIL reset_async got=%h exp=%h", dut_a_vec, 45'd0);
      end
      tick();
      tick();
      checks++;
      if (dut_a_vec !== exp_vec(e_wbd8, e_pct8)) begin
         errors++;
         $display("[TB] FAIL reset_held_a got=%h exp=%h", dut_a_vec, exp_vec(e_wbd8, e_pct8));
      end
      checks++;
      if (dut_b_vec !== 45'd0) begin
         errors++;
         $display("[TB] FAIL reset_held_b got=%h exp=%h", dut_b_vec, 45'd0);
      end
      rst = 1'b1;
   endtask

   // Give every location a known value below 8'h80 so later checks can tell
   // bit-7 patterns apart from leftovers.
   task automatic init_memory();
      for (int i = 0; i < 256; i++) begin
         set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i), 8'($urandom_range(0, 127)));
         tick();
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_store_load();
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'hA5);
      tick();
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
      tick();
      checks++;
      if (wb_data_a !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL load_after_store got=%h exp=%h", wb_data_a, 8'hA5);
      end
      checks++;
      if (wb_reg_write_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL load_wb_reg_write got=%b exp=1", wb_reg_write_a);
      end
   endtask

   task automatic test_io();
      clear_inputs();
      in_port = 8'h3C;
      tick();
      tick();
      tick();
      set_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, 8'h00);
      tick();
      checks++;
      if (wb_data_a !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL in_port_read got=%h exp=%h", wb_data_a, 8'h3C);
      end
      set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h77);
      tick();
      checks++;
      if (out_port_a !== 8'h77) begin
         errors++;
         $display("[TB] FAIL out_port_load got=%h exp=%h", out_port_a, 8'h77);
      end
      clear_inputs();
      store_data_in = 8'h12;
      tick();
      tick();
      checks++;
      if (out_port_a !== 8'h77) begin
         errors++;
         $display("[TB] FAIL out_port_hold got=%h exp=%h", out_port_a, 8'h77);
      end
   endtask

   task automatic test_ret();
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h42);
      tick();
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h00);
      tick();
      checks++;
      if ({pc_load_a, flush_a, pc_target_a} !== {1'b1, 1'b1, 8'h42}) begin
         errors++;
         $display("[TB] FAIL ret_redirect got=%b%b/%h exp=11/42", pc_load_a, flush_a, pc_target_a);
      end
      checks++;
      if ({wb_reg_write_a, wb_data_a} !== {1'b1, 8'h42}) begin
         errors++;
         $display("[TB] FAIL ret_writeback got=%b/%h exp=1/42", wb_reg_write_a, wb_data_a);
      end
      clear_inputs();
      tick();
      checks++;
      if ({pc_load_a, flush_a} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL ret_pulse_width got=%b%b exp=00", pc_load_a, flush_a);
      end
      // Wrong-path instruction in the drain slot, including a stray RET.
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 8'hD5);
      sp_update_in    = 1'b1;
      update_flags_in = 1'b1;
      tick();
      checks++;
      if ({wb_reg_write_a, sp_update_a, update_flags_a} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL drain_squash got=%b%b%b exp=000", wb_reg_write_a, sp_update_a,
                  update_flags_a);
      end
      checks++;
      if (out_port_a !== 8'h77) begin
         errors++;
         $display("[TB] FAIL drain_out_port got=%h exp=%h", out_port_a, 8'h77);
      end
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
      tick();
      checks++;
      if (pc_load_a !== 1'b0 || wb_data_a === 8'hD5) begin
         errors++;
         $display("[TB] FAIL drain_no_store got=%b/%h exp=0/not d5", pc_load_a, wb_data_a);
      end
      checks++;
      if (dut_a_vec !== exp_vec(e_wbd8, e_pct8)) begin
         errors++;
         $display("[TB] FAIL ret_vec got=%h exp=%h", dut_a_vec, exp_vec(e_wbd8, e_pct8));
      end
      // RET without a memory read is malformed and must not redirect.
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h00);
      tick();
      checks++;
      if (pc_load_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ret_no_m2r got=%b exp=0", pc_load_a);
      end
   endtask

   task automatic test_stall();
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00);
      tick();
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 8'h99);
      stall_in = 1'b1;
      tick();
      tick();
      checks++;
      if ({wb_reg_write_a, wb_data_a, out_port_a} !== {1'b1, 8'h5A, 8'h77}) begin
         errors++;
         $display("[TB] FAIL stall_freeze got=%b/%h/%h exp=1/5a/77", wb_reg_write_a, wb_data_a,
                  out_port_a);
      end
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00);
      tick();
      checks++;
      if (wb_data_a === 8'h99) begin
         errors++;
         $display("[TB] FAIL stall_no_write got=%h exp=not 99", wb_data_a);
      end
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 8'h99);
      stall_in = 1'b1;
      tick();
      stall_in = 1'b0;
      tick();
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00);
      tick();
      checks++;
      if (wb_data_a !== 8'h99) begin
         errors++;
         $display("[TB] FAIL stall_release_store got=%h exp=%h", wb_data_a, 8'h99);
      end
   endtask

   task automatic test_reset_mid_ret();
      int pulses;
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h00);
      tick();
      checks++;
      if (pc_load_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pre_reset_redirect got=%b exp=1", pc_load_a);
      end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_a_vec !== 45'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid_ret got=%h exp=%h", dut_a_vec, 45'd0);
      end
      clear_inputs();
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) rst = 1'b1;
         tick();
         if (pc_load_a !== 1'b0 || flush_a !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL reset_abort_pulses got=%0d exp=0", pulses);
      end
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'hC4);
      tick();
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
      tick();
      checks++;
      if (wb_data_a !== 8'hC4) begin
         errors++;
         $display("[TB] FAIL post_reset_load got=%h exp=%h", wb_data_a, 8'hC4);
      end
   endtask

   task automatic test_addr_wrap();
      set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13, 8'hE7);
      tick();
      set_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00);
      tick();
      checks++;
      if (wb_data_b !== 8'hE7) begin
         errors++;
         $display("[TB] FAIL addr_wrap_a4 got=%h exp=%h", wb_data_b, 8'hE7);
      end
      checks++;
      if (wb_data_a === 8'hE7) begin
         errors++;
         $display("[TB] FAIL addr_nowrap_a8 got=%h exp=not e7", wb_data_a);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         clear_inputs();
         is_ret_in       = ($urandom_range(0, 7) == 0);
         mem_to_reg_in   = is_ret_in ? ($urandom_range(0, 3) != 0) : 1'($urandom);
         stall_in        = ($urandom_range(0, 3) == 0);
         wb_reg_write_in = 1'($urandom);
         mem_write_in    = ($urandom_range(0, 3) == 0);
         io_read_in      = 1'($urandom);
         io_write_in     = ($urandom_range(0, 3) == 0);
         sp_update_in    = 1'($urandom);
         update_flags_in = 1'($urandom);
         alu_result_in   = 8'($urandom);
         store_data_in   = 8'($urandom);
         extra_data_in   = 8'($urandom);
         write_addr_in   = 2'($urandom);
         sp_addr_in      = 2'($urandom);
         flags_in        = 4'($urandom);
         in_port         = 8'($urandom);
         tick();
         checks++;
         if (dut_a_vec !== exp_vec(e_wbd8, e_pct8)) begin
            errors++;
            $display("[TB] FAIL rand_a cyc=%0d got=%h exp=%h", n, dut_a_vec,
                     exp_vec(e_wbd8, e_pct8));
         end
         checks++;
         if (dut_b_vec !== exp_vec(e_wbd4, e_pct4)) begin
            errors++;
            $display("[TB] FAIL rand_b cyc=%0d got=%h exp=%h", n, dut_b_vec,
                     exp_vec(e_wbd4, e_pct4));
         end
      end
   endtask

   initial begin
      test_reset();
      init_memory();
      test_store_load();
      test_io();
      test_ret();
      test_stall();
      test_reset_mid_ret();
      test_addr_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
